// File: rtl/noc_vc_link_scheduler_pkg.sv
// Shared NoC parameters and types used by the link scheduler and its arbiter.
package Noc_parameters;

  localparam int Noc_VC_Channel = 4;
  localparam int Noc_Data_Width = 32;

  typedef logic [$clog2(Noc_VC_Channel)-1:0] vc_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin priority pick: first requester at or above ptr, with wrap-around.
module noc_rr_arbiter
  import Noc_parameters::*;
#(
  parameter int N = Noc_VC_Channel,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_link_scheduler.sv
// Multiplexes per-VC flit streams onto one registered single-flit link with
// round-robin arbitration, optional packet locking and per-VC framing checks.
module noc_vc_link_scheduler
  import Noc_parameters::*;
#(
  parameter int Channel     = Noc_VC_Channel,
  parameter int Data_width  = Noc_Data_Width,
  parameter bit Lock_Packet = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [Channel-1:0]                  in_valid,
  output logic [Channel-1:0]                  in_ready,
  input  logic [Channel-1:0][Data_width-1:0]  in_flit,
  input  logic [Channel-1:0]                  in_is_header,
  input  logic [Channel-1:0]                  in_is_tail,
  output logic [Channel-1:0]                  out_valid,
  input  logic [Channel-1:0]                  out_ready,
  input  logic [Channel-1:0]                  out_vc_ready,
  output logic [Data_width-1:0]               out_flit,
  output logic                                out_is_header,
  output logic                                out_is_tail,
  output logic                                proto_err
);

  localparam int IDX_W = $clog2(Channel);

  logic                  slot_valid_reg;
  logic [IDX_W-1:0]      slot_vc_reg;
  logic [Data_width-1:0] slot_flit_reg;
  logic                  slot_hdr_reg;
  logic                  slot_tail_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  lock_state_t           lock_state_reg;
  logic [IDX_W-1:0]      lock_vc_reg;
  logic                  proto_err_reg;

  logic                  slot_drain;
  logic                  slot_free;
  logic [Channel-1:0]    eligible;
  logic [Channel-1:0]    req;
  logic [Channel-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  grant_hdr;
  logic                  grant_tail;
  logic                  grant_err;
  logic [Channel-1:0]    pkt_open;
  logic [IDX_W-1:0]      rr_ptr_next;

  assign slot_drain = slot_valid_reg && out_ready[slot_vc_reg];
  assign slot_free  = !slot_valid_reg || slot_drain;

  for (genvar gi = 0; gi < Channel; gi++) begin : g_vc
    logic holds_vc;
    logic lock_ok;
    logic pkt_open_reg;

    assign holds_vc     = slot_valid_reg && (slot_vc_reg == IDX_W'(gi));
    assign lock_ok      = (lock_state_reg == UNLOCKED) || (lock_vc_reg == IDX_W'(gi));
    assign eligible[gi] = in_valid[gi] && out_vc_ready[gi] && !(holds_vc && !slot_drain) && lock_ok;
    assign out_valid[gi] = holds_vc;
    assign pkt_open[gi]  = pkt_open_reg;

    // Tail wins over header so a single-flit packet leaves the VC closed.
    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_open_reg <= 1'b0;
      end else if (grant[gi]) begin
        if (in_is_tail[gi])        pkt_open_reg <= 1'b0;
        else if (in_is_header[gi]) pkt_open_reg <= 1'b1;
      end
    end
  end

  assign req      = (rst || !slot_free) ? '0 : eligible;
  assign in_ready = grant;

  noc_rr_arbiter #(
    .N (Channel)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_hdr   = in_is_header[grant_idx];
  assign grant_tail  = in_is_tail[grant_idx];
  assign grant_err   = grant_valid && (grant_hdr ? pkt_open[grant_idx] : !pkt_open[grant_idx]);
  assign rr_ptr_next = (grant_idx == IDX_W'(Channel - 1)) ? '0 : grant_idx + IDX_W'(1);

  // A new grant overwrites the slot in the same edge it drains, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_reg <= 1'b0;
      slot_vc_reg    <= '0;
      slot_flit_reg  <= '0;
      slot_hdr_reg   <= 1'b0;
      slot_tail_reg  <= 1'b0;
      rr_ptr_reg     <= '0;
    end else if (grant_valid) begin
      slot_valid_reg <= 1'b1;
      slot_vc_reg    <= grant_idx;
      slot_flit_reg  <= in_flit[grant_idx];
      slot_hdr_reg   <= grant_hdr;
      slot_tail_reg  <= grant_tail;
      rr_ptr_reg     <= rr_ptr_next;
    end else if (slot_drain) begin
      slot_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_reg <= UNLOCKED;
      lock_vc_reg    <= '0;
    end else if (Lock_Packet && grant_valid) begin
      case (lock_state_reg)
        UNLOCKED: begin
          if (grant_hdr && !grant_tail) begin
            lock_state_reg <= LOCKED;
            lock_vc_reg    <= grant_idx;
          end
        end
        LOCKED: begin
          if (grant_tail) lock_state_reg <= UNLOCKED;
        end
        default: lock_state_reg <= UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            proto_err_reg <= 1'b0;
    else if (grant_err) proto_err_reg <= 1'b1;
  end

  assign out_flit      = slot_flit_reg;
  assign out_is_header = slot_hdr_reg;
  assign out_is_tail   = slot_tail_reg;
  assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_noc_vc_link_scheduler.sv
// Two schedulers (index 0 interleaving, index 1 packet-locked) checked against a
// behavioural model with directed scenarios followed by random traffic.
module tb_noc_vc_link_scheduler;

  localparam int CH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH-1:0]         in_valid_a     [2];
  logic [CH-1:0]         in_hdr_a       [2];
  logic [CH-1:0]         in_tail_a      [2];
  logic [CH-1:0][DW-1:0] in_flit_a      [2];
  logic [CH-1:0]         out_ready_a    [2];
  logic [CH-1:0]         out_vc_ready_a [2];
  logic [CH-1:0]         in_ready_a     [2];
  logic [CH-1:0]         out_valid_a    [2];
  logic [DW-1:0]         out_flit_a     [2];
  logic                  out_hdr_a      [2];
  logic                  out_tail_a     [2];
  logic                  proto_err_a    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    noc_vc_link_scheduler #(
      .Channel     (CH),
      .Data_width  (DW),
      .Lock_Packet (gi == 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid_a[gi]),
      .in_ready      (in_ready_a[gi]),
      .in_flit       (in_flit_a[gi]),
      .in_is_header  (in_hdr_a[gi]),
      .in_is_tail    (in_tail_a[gi]),
      .out_valid     (out_valid_a[gi]),
      .out_ready     (out_ready_a[gi]),
      .out_vc_ready  (out_vc_ready_a[gi]),
      .out_flit      (out_flit_a[gi]),
      .out_is_header (out_hdr_a[gi]),
      .out_is_tail   (out_tail_a[gi]),
      .proto_err     (proto_err_a[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: link slot, pointer, lock and open-packet flags per instance.
  bit          m_sv    [2];
  int          m_svc   [2];
  logic [7:0]  m_sflit [2];
  bit          m_sh    [2];
  bit          m_st    [2];
  int          m_ptr   [2];
  bit          m_lk    [2];
  int          m_lkvc  [2];
  bit          m_err   [2];
  bit          m_open  [2*CH];
  int          m_grant [2];

  int          obs_q [2][$];
  logic [9:0]  src_q [2*CH][$];
  bit          feed_mode;
  int          exp_seq[$];

  function automatic void model_reset(int d);
    m_sv[d] = 0; m_svc[d] = 0; m_sflit[d] = '0; m_sh[d] = 0; m_st[d] = 0;
    m_ptr[d] = 0; m_lk[d] = 0; m_lkvc[d] = 0; m_err[d] = 0;
    for (int v = 0; v < CH; v++) m_open[d*CH+v] = 0;
  endfunction

  function automatic int model_pick(int d);
    if (rst) return -1;
    if (m_sv[d] && !out_ready_a[d][m_svc[d]]) return -1;
    for (int k = 0; k < CH; k++) begin
      int v;
      v = (m_ptr[d] + k) % CH;
      if (in_valid_a[d][v] && out_vc_ready_a[d][v] && (!m_lk[d] || v == m_lkvc[d])) return v;
    end
    return -1;
  endfunction

  function automatic void model_update(int d);
    int g;
    bit drain;
    g = m_grant[d];
    if (rst) begin
      model_reset(d);
      return;
    end
    drain = m_sv[d] && out_ready_a[d][m_svc[d]];
    if (g >= 0) begin
      bit h, t;
      int k;
      h = in_hdr_a[d][g];
      t = in_tail_a[d][g];
      k = d*CH + g;
      if (h && m_open[k])   m_err[d] = 1;
      if (!h && !m_open[k]) m_err[d] = 1;
      if (t) m_open[k] = 0;
      else if (h) m_open[k] = 1;
      if (d == 1) begin
        if (t) m_lk[d] = 0;
        else if (h) begin m_lk[d] = 1; m_lkvc[d] = g; end
      end
      m_sv[d] = 1; m_svc[d] = g; m_sflit[d] = in_flit_a[d][g]; m_sh[d] = h; m_st[d] = t;
      m_ptr[d] = (g + 1) % CH;
    end else if (drain) begin
      m_sv[d] = 0;
    end
  endfunction

  function automatic int onehot_idx(logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_feed();
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < CH; v++) begin
        logic [9:0] e;
        e = '0;
        if (src_q[d*CH+v].size() > 0) e = src_q[d*CH+v][0];
        in_valid_a[d][v] = (src_q[d*CH+v].size() > 0);
        in_hdr_a[d][v]   = e[9];
        in_tail_a[d][v]  = e[8];
        in_flit_a[d][v]  = e[7:0];
      end
    end
  endtask

  task automatic push(input int v, input bit h, input bit t, input logic [7:0] f);
    for (int d = 0; d < 2; d++) src_q[d*CH+v].push_back({h, t, f});
  endtask

  // One clock: check in_ready, log link transfers, advance model, check outputs.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      m_grant[d] = model_pick(d);
      check($sformatf("in_ready%0d", d), in_ready_a[d], (m_grant[d] < 0) ? 0 : (1 << m_grant[d]));
      if ((out_valid_a[d] & out_ready_a[d]) != 0) begin
        int vc;
        vc = onehot_idx(out_valid_a[d]);
        obs_q[d].push_back(vc*256 + int'(out_flit_a[d]));
        $display("xfer dut%0d vc%0d flit %02h hdr %0b tail %0b", d, vc, out_flit_a[d], out_hdr_a[d], out_tail_a[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_update(d);
      if (feed_mode && m_grant[d] >= 0 && !rst) void'(src_q[d*CH+m_grant[d]].pop_front());
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("out_valid%0d", d), out_valid_a[d], m_sv[d] ? (1 << m_svc[d]) : 0);
      if (m_sv[d]) begin
        check($sformatf("out_flit%0d", d), out_flit_a[d], m_sflit[d]);
        check($sformatf("out_hdr%0d", d), out_hdr_a[d], m_sh[d]);
        check($sformatf("out_tail%0d", d), out_tail_a[d], m_st[d]);
      end
      check($sformatf("proto_err%0d", d), proto_err_a[d], m_err[d]);
    end
    if (feed_mode) drive_feed();
  endtask

  task automatic set_link(input logic [CH-1:0] ordy, input logic [CH-1:0] vrdy);
    for (int d = 0; d < 2; d++) begin
      out_ready_a[d]    = ordy;
      out_vc_ready_a[d] = vrdy;
    end
  endtask

  task automatic all_singles();
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = '1; in_hdr_a[d] = '1; in_tail_a[d] = '1;
      for (int v = 0; v < CH; v++) in_flit_a[d][v] = 8'(8'hC0 + v);
    end
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin in_valid_a[d] = '0; in_hdr_a[d] = '0; in_tail_a[d] = '0; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2*CH; i++) src_q[i].delete();
    for (int d = 0; d < 2; d++) obs_q[d].delete();
  endtask

  task automatic check_seq(input string tag, input int d);
    check($sformatf("%s%0d_len", tag, d), obs_q[d].size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size() && k < obs_q[d].size(); k++)
      check($sformatf("%s%0d_%0d", tag, d, k), obs_q[d][k], exp_seq[k]);
  endtask

  function automatic logic [CH-1:0] rbits(int pct);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (int'($urandom_range(0, 99)) < pct);
    return r;
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    feed_mode = 0;
    set_link('1, '1);
    all_singles();
    rst = 1'b1;
    @(negedge clk);

    // Reset held with every VC valid.
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", in_ready_a[d], 0);
      check("rst_out_valid", out_valid_a[d], 0);
      check("rst_out_flit", out_flit_a[d], 0);
      check("rst_proto_err", proto_err_a[d], 0);
    end

    // Round robin with continuous single-flit packets.
    rst = 1'b0;
    for (int d = 0; d < 2; d++) obs_q[d].delete();
    repeat (7) step();
    exp_seq = '{32'h0C0, 32'h1C1, 32'h2C2, 32'h3C3, 32'h0C0, 32'h1C1};
    for (int d = 0; d < 2; d++) check_seq("rr", d);

    // VC1 H,B,T against a VC2 single-flit packet.
    do_reset();
    feed_mode = 1;
    push(1, 1, 0, 8'h11); push(1, 0, 0, 8'h12); push(1, 0, 1, 8'h13);
    push(2, 1, 1, 8'h21);
    drive_feed();
    repeat (6) step();
    exp_seq = '{32'h111, 32'h221, 32'h112, 32'h113};
    check_seq("nolock", 0);
    exp_seq = '{32'h111, 32'h112, 32'h113, 32'h221};
    check_seq("lock", 1);

    // Backpressure on VC0 holding 0xA5.
    do_reset();
    set_link(4'b1110, '1);
    push(0, 1, 1, 8'hA5);
    push(1, 1, 1, 8'hB1);
    drive_feed();
    step();
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) begin
        check("bp_flit", out_flit_a[d], 8'hA5);
        check("bp_in_ready", in_ready_a[d], 0);
      end
    end
    set_link('1, '1);
    step();
    step();
    exp_seq = '{32'h0A5, 32'h1B1};
    for (int d = 0; d < 2; d++) check_seq("bp", d);

    // Downstream VC2 unavailable, then released.
    feed_mode = 0;
    do_reset();
    all_singles();
    set_link('1, 4'b1011);
    repeat (8) step();
    for (int d = 0; d < 2; d++) begin
      int n;
      n = 0;
      foreach (obs_q[d][k]) if (obs_q[d][k] / 256 == 2) n++;
      check("avail_vc2_blocked", n, 0);
      obs_q[d].delete();
    end
    set_link('1, '1);
    repeat (8) step();
    for (int d = 0; d < 2; d++) begin
      int n;
      n = 0;
      foreach (obs_q[d][k]) if (obs_q[d][k] / 256 == 2) n++;
      check("avail_vc2_granted", (n > 0), 1);
    end

    // Framing errors, then reset in the middle of a packet.
    do_reset();
    feed_mode = 1;
    push(3, 0, 0, 8'h30);
    drive_feed();
    step();
    for (int d = 0; d < 2; d++) check("frame_err_set", proto_err_a[d], 1);
    repeat (3) step();
    for (int d = 0; d < 2; d++) check("frame_err_sticky", proto_err_a[d], 1);
    push(1, 1, 0, 8'h41);
    drive_feed();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) check("frame_err_cleared", proto_err_a[d], 0);
    push(2, 1, 1, 8'h52);
    drive_feed();
    step();
    for (int d = 0; d < 2; d++) check("fresh_vc2_granted", out_valid_a[d], 4'b0100);
    push(1, 1, 0, 8'h61);
    drive_feed();
    step();
    for (int d = 0; d < 2; d++) begin
      check("fresh_hdr_granted", out_valid_a[d], 4'b0010);
      check("fresh_hdr_no_err", proto_err_a[d], 0);
    end

    // Random traffic, backpressure, availability and occasional reset.
    feed_mode = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        in_valid_a[d]     = rbits(60);
        in_hdr_a[d]       = rbits(35);
        in_tail_a[d]      = rbits(50);
        out_ready_a[d]    = rbits(80);
        out_vc_ready_a[d] = rbits(85);
        for (int v = 0; v < CH; v++) in_flit_a[d][v] = 8'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_vc_link_scheduler.md
# noc_vc_link_scheduler

Output-side scheduler for one NoC physical link. It takes `Channel` per-VC flit streams from the router's VC buffers and multiplexes them onto one single-flit link, toward a downstream receiver such as an external port. Arbitration is round-robin and gated by downstream VC availability. A parameter enables packet locking, which holds the grant on one VC from header to tail. The output is registered, and the block also monitors header/tail framing for each VC.

## Interface
- `Channel`, `Noc_VC_Channel`: number of virtual channels (≥2).
- `Data_width`, `Noc_Data_Width`: flit width.
- `Lock_Packet`, 0: 0 means flits from different VCs interleave freely; 1 means a granted VC keeps the link until its tail flit.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input [Channel]: VC i presents a flit.
- `in_ready` output [Channel]: flit on VC i accepted this cycle; one-hot or zero.
- `in_flit` input [Channel][Data_width]: per-VC flit data.
- `in_is_header` input [Channel]: flit is a packet header.
- `in_is_tail` input [Channel]: flit is a packet tail (header+tail = single-flit packet).
- `out_valid` output [Channel]: one-hot; link slot holds a flit for that VC.
- `out_ready` input [Channel]: downstream accepts on VC i.
- `out_vc_ready` input [Channel]: downstream VC i can take one more flit beyond any flit in flight.
- `out_flit` output [Data_width]: link flit.
- `out_is_header`, `out_is_tail` output 1: framing of the link flit.
- `proto_err` output 1: sticky framing-error flag.

## Operation
- Slot: one output register holding flit, VC index, header bit, tail bit and valid bit.
- Drain: the slot is consumed when `out_valid[v] && out_ready[v]`.
- Slot free: the slot can load when it is empty or is being drained this cycle.
- Eligible VC i: `in_valid[i] && out_vc_ready[i]`, and not (slot holds VC i and is not draining), and the lock permits i.
- Grant: if the slot is free, grant the first eligible VC scanning from `rr_ptr` upward with wrap-around. `in_ready[grant]=1`, and the slot loads that flit on the clock edge.
- Pointer: after each grant, `rr_ptr <= (grant+1) mod Channel`. The pointer does not move when nothing is granted.
- Lock FSM when `Lock_Packet=1`. States are UNLOCKED and LOCKED(vc).
  - UNLOCKED → LOCKED(g) when the granted flit is a header and not a tail.
  - LOCKED(g): only VC g is eligible.
  - LOCKED(g) → UNLOCKED on the transfer of the tail from g.
  - When `Lock_Packet=0` the FSM stays UNLOCKED.
- Framing monitor: one `pkt_open` bit per VC, updated on each accepted input flit.
  - Header with `pkt_open` set → error.
  - Non-header with `pkt_open` clear → error.
  - Header-not-tail sets `pkt_open`; tail clears it.
  - On error, `proto_err <= 1` and it stays set until `rst`. The flit is still forwarded.

## Timing
- Reset state: `out_valid=0`, `out_flit=0`, `out_is_header=0`, `out_is_tail=0`, `proto_err=0`, `rr_ptr=0`, FSM UNLOCKED, all `pkt_open=0`.
  - `in_ready=0` in the reset cycle regardless of inputs.
- Latency: a flit accepted at edge n appears at the output after edge n, i.e. one cycle.
- Throughput: one flit per cycle under continuous `out_ready`.
- `in_ready` is combinational from `in_valid`, `out_vc_ready`, `out_ready` and registered state. There is no combinational path to `out_flit`.
- While `out_valid[v]=1 && !out_ready[v]`, `out_flit` and framing outputs stay stable.
- Simultaneous drain and load: the new flit replaces the slot in the same edge, with no bubble.
- Lock on a VC whose `out_vc_ready` is low: the link idles. No other VC is granted.
- `rst` asserted mid-packet: the slot, lock and `pkt_open` state are discarded in the same edge. Upstream and downstream must reset together.

## Structure
- Shared package `Noc_parameters`: `Noc_VC_Channel`, `Noc_Data_Width`, and a new `vc_idx_t` typedef (`$clog2(Noc_VC_Channel)` bits).
- Sub-module `noc_rr_arbiter`: parameterised round-robin priority pick (request vector, pointer → one-hot grant). It is reusable by the switch allocator.
- Everything else lives in `noc_vc_link_scheduler`.

## Test plan
- Reset: assert `rst` for 2 cycles with all `in_valid=1`. Required: `in_ready=0`, `out_valid=0`, `proto_err=0`.
- Round-robin: `Channel=4`, all VCs continuously valid with single-flit packets, `out_ready`/`out_vc_ready` all 1. Required: grant order 0,1,2,3,0,1 at one flit/cycle.
- Lock: `Lock_Packet=1`. VC1 sends H,B,T while VC2 holds a single-flit packet valid. Required: link carries VC1 H,B,T, then VC2.
  - With `Lock_Packet=0`, same stimulus: link carries VC1 H, VC2, VC1 B, VC1 T.
- Backpressure: hold `out_ready[0]=0` for 3 cycles with flit 0xA5 in the slot on VC0. Required: `out_flit` stays 0xA5; VC0 is not granted; VC1 is not granted because the slot is not free.
- Availability: `out_vc_ready[2]=0` with all VCs valid. Required: VC2 is never granted until the signal rises, then it is granted in rotation.
- Framing and reset mid-packet:
  - A body flit on an idle VC3 → `proto_err=1` next cycle, and it stays set.
  - `rst` pulsed mid-packet → `proto_err=0`, UNLOCKED, and a fresh header is accepted with no error.
